// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared slot record, forwarding select codes and memory-wait states
package pipe_ctrl_pkg;
  localparam int SLOT_AW = 8;
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] dest;
    logic               wb_en;
    logic               mem_r_en;
    logic               mem_acc;
  } slot_t;
  typedef enum logic {S_IDLE, S_WAIT} mem_state_t;
endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: EX/MEM/WB in-flight slots plus EX-aligned sources, with hold and bubble insert
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int N_SRC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    load,
  input  slot_t                   id_slot,
  input  logic [N_SRC*REG_AW-1:0] id_src,
  input  logic [N_SRC-1:0]        id_used,
  output slot_t                   ex,
  output slot_t                   mem,
  output slot_t                   wb,
  output logic [N_SRC*REG_AW-1:0] ex_src,
  output logic [N_SRC-1:0]        ex_used
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex      <= '0;
      mem     <= '0;
      wb      <= '0;
      ex_src  <= '0;
      ex_used <= '0;
    end else if (!hold) begin
      wb      <= mem;
      mem     <= ex;
      ex      <= load ? id_slot : '0;
      ex_src  <= load ? id_src : '0;
      ex_used <= load ? id_used : '0;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze, operand forwarding and memory wait-state control for the 5-stage core
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int N_SRC   = 2,
  parameter int FWD_EN  = 1,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [N_SRC*REG_AW-1:0] id_src,
  input  logic [N_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]       id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_r_en,
  input  logic                    id_mem_w_en,
  input  logic                    branch_taken,
  input  logic                    mem_ready,
  output logic                    hazard_stall,
  output logic                    flush_if,
  output logic                    flush_id,
  output logic                    freeze_all,
  output logic [N_SRC*2-1:0]      fwd_sel,
  output logic                    mem_timeout,
  output logic [CNT_W-1:0]        stall_cnt
);
  localparam int WW = $clog2(TIMEOUT + 1);
  slot_t ex, mem, wb, id_slot;
  logic [N_SRC*REG_AW-1:0] ex_src;
  logic [N_SRC-1:0] ex_used, hit_ex, hit_mem;
  logic raw_stall, flush, load;
  mem_state_t state;
  logic [WW-1:0] wcnt, wnext;
  function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.wb_en & (s.dest == SLOT_AW'(r));
  endfunction
  assign id_slot = '{valid: 1'b1, dest: SLOT_AW'(id_dest), wb_en: id_wb_en,
                     mem_r_en: id_mem_r_en, mem_acc: id_mem_r_en | id_mem_w_en};
  pipe_scoreboard #(.REG_AW(REG_AW), .N_SRC(N_SRC)) u_sb (
    .clk(clk), .rst(rst), .hold(freeze_all), .load(load), .id_slot(id_slot),
    .id_src(id_src), .id_used(id_src_used), .ex(ex), .mem(mem), .wb(wb),
    .ex_src(ex_src), .ex_used(ex_used)
  );
  always_comb begin
    hit_ex  = '0;
    hit_mem = '0;
    fwd_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      hit_ex[i]  = id_valid & id_src_used[i] & hit(ex, id_src[i*REG_AW +: REG_AW]);
      hit_mem[i] = id_valid & id_src_used[i] & hit(mem, id_src[i*REG_AW +: REG_AW]);
      if (FWD_EN != 0 && ex_used[i])
        fwd_sel[2*i +: 2] = (hit(mem, ex_src[i*REG_AW +: REG_AW]) & !mem.mem_r_en) ? FWD_MEM :
                            hit(wb, ex_src[i*REG_AW +: REG_AW]) ? FWD_WB : FWD_REG;
    end
  end
  assign raw_stall    = (FWD_EN != 0) ? (|hit_ex) & ex.mem_r_en : |{hit_ex, hit_mem};
  assign freeze_all   = mem.valid & mem.mem_acc & !mem_ready;
  assign flush        = rst & branch_taken & !freeze_all;
  assign flush_if     = flush;
  assign flush_id     = flush;
  assign hazard_stall = raw_stall & !flush & !freeze_all;
  assign load         = id_valid & !hazard_stall & !flush;
  // a frozen pipeline keeps the access in MEM, so the wait condition itself drives the FSM
  assign wnext = (state == S_IDLE) ? WW'(1) : (&wcnt) ? wcnt : wcnt + WW'(1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(hazard_stall | freeze_all);
      if (freeze_all) begin
        state <= S_WAIT;
        wcnt  <= wnext;
        if (wnext >= WW'(TIMEOUT)) mem_timeout <= 1'b1;
      end else begin
        state <= S_IDLE;
        wcnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench driving a stall-only and a forwarding instance side by side
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst = 0;
  logic id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, branch_taken, mem_ready;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic [3:0] id_dest;
  logic hs0, fi0, fd0, fa0, to0, hs1, fi1, fd1, fa1, to1;
  logic [3:0] fwd0, fwd1;
  logic [31:0] sc0, sc1;
  typedef struct packed {
    logic v; logic [3:0] s0, s1; logic [1:0] u; logic [3:0] dst;
    logic wb, mr, br, rdy; logic [8:0] e;
  } row_t;
  typedef struct {bit d; logic [8:0] v;} exp_t;
  exp_t q[$];
  exp_t ex;
  logic [8:0] got;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(0), .TIMEOUT(255)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .hazard_stall(hs0), .flush_if(fi0),
    .flush_id(fd0), .freeze_all(fa0), .fwd_sel(fwd0), .mem_timeout(to0), .stall_cnt(sc0)
  );
  pipe_hazard_ctrl #(.FWD_EN(1), .TIMEOUT(2)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .hazard_stall(hs1), .flush_if(fi1),
    .flush_id(fd1), .freeze_all(fa1), .fwd_sel(fwd1), .mem_timeout(to1), .stall_cnt(sc1)
  );

  function automatic logic [8:0] obs(input bit d);
    return d ? {hs1, fi1, fd1, fa1, fwd1, to1} : {hs0, fi0, fd0, fa0, fwd0, to0};
  endfunction

  function automatic row_t mk(input int v, s0, s1, u, dst, wb, mr, br, rdy, e);
    mk.v = v[0]; mk.s0 = 4'(s0); mk.s1 = 4'(s1); mk.u = 2'(u); mk.dst = 4'(dst);
    mk.wb = wb[0]; mk.mr = mr[0]; mk.br = br[0]; mk.rdy = rdy[0]; mk.e = 9'(e);
  endfunction

  task automatic apply(input bit d, input row_t r);
    id_valid = r.v; id_src = {r.s1, r.s0}; id_src_used = r.u; id_dest = r.dst;
    id_wb_en = r.wb; id_mem_r_en = r.mr; id_mem_w_en = 1'b0;
    branch_taken = r.br; mem_ready = r.rdy;
    q.push_back('{d, r.e});
  endtask

  task automatic do_reset();
    rst = 0; id_valid = 0; branch_taken = 0; mem_ready = 1;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    id_valid = 1; id_src = 8'h11; id_src_used = 2'b11; id_dest = 4'd1; id_wb_en = 1;
    id_mem_r_en = 1; id_mem_w_en = 0; branch_taken = 1; mem_ready = 0;
    q.push_back('{0, 9'b0}); q.push_back('{1, 9'b0});
    #3;
    for (int i = 0; i < 2; i++) begin
      ex = q.pop_front(); got = obs(ex.d); vecs++;
      if (got !== ex.v) begin errs++; $display("FAIL reset dut%0d: got %b want %b", ex.d, got, ex.v); end
    end
    vecs++;
    if (sc0 !== 32'd0 || sc1 !== 32'd0) begin errs++; $display("FAIL reset stall_cnt: got %0d/%0d want 0", sc0, sc1); end
    branch_taken = 0; mem_ready = 1; id_valid = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_stall_no_fwd();
    row_t t[5];
    t = '{mk(1,2,3,3,1,1,0,0,1, 'b000000000), mk(1,1,3,3,2,1,0,0,1, 'b100000000),
          mk(1,1,3,3,2,1,0,0,1, 'b100000000), mk(1,1,3,3,2,1,0,0,1, 'b000000000),
          mk(0,0,0,0,0,0,0,0,1, 'b000000000)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(0, t[i]);
      @(negedge clk); ex = q.pop_front(); got = obs(ex.d); vecs++;
      if (got !== ex.v) begin errs++; $display("FAIL stall_nofwd[%0d]: got %b want %b", i, got, ex.v); end
      @(posedge clk); #1;
    end
    vecs++;
    if (sc0 !== 32'd2) begin errs++; $display("FAIL stall_nofwd stall_cnt: got %0d want 2", sc0); end
  endtask

  task automatic test_forward();
    row_t t[4], u[4];
    t = '{mk(1,2,3,3,1,1,0,0,1, 'b000000000), mk(1,1,3,3,2,1,0,0,1, 'b000000000),
          mk(0,0,0,0,0,0,0,0,1, 'b000000010), mk(0,0,0,0,0,0,0,0,1, 'b000000000)};
    u = '{mk(1,2,3,3,1,1,0,0,1, 'b000000000), mk(1,7,8,3,6,1,0,0,1, 'b000000000),
          mk(1,1,3,3,2,1,0,0,1, 'b000000000), mk(0,0,0,0,0,0,0,0,1, 'b000000100)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, t[i]);
      @(negedge clk); ex = q.pop_front(); got = obs(ex.d); vecs++;
      if (got !== ex.v) begin errs++; $display("FAIL fwd_mem[%0d]: got %b want %b", i, got, ex.v); end
      @(posedge clk); #1;
    end
    vecs++;
    if (sc1 !== 32'd0) begin errs++; $display("FAIL fwd stall_cnt: got %0d want 0", sc1); end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, u[i]);
      @(negedge clk); ex = q.pop_front(); got = obs(ex.d); vecs++;
      if (got !== ex.v) begin errs++; $display("FAIL fwd_wb[%0d]: got %b want %b", i, got, ex.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t t[4];
    t = '{mk(1,0,0,1,4,1,1,0,1, 'b000000000), mk(1,4,4,3,5,1,0,0,1, 'b100000000),
          mk(1,4,4,3,5,1,0,0,1, 'b000000000), mk(0,0,0,0,0,0,0,0,1, 'b000010100)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, t[i]);
      @(negedge clk); ex = q.pop_front(); got = obs(ex.d); vecs++;
      if (got !== ex.v) begin errs++; $display("FAIL load_use[%0d]: got %b want %b", i, got, ex.v); end
      @(posedge clk); #1;
    end
    vecs++;
    if (sc1 !== 32'd1) begin errs++; $display("FAIL load_use stall_cnt: got %0d want 1", sc1); end
  endtask

  task automatic test_branch_flush();
    row_t t[4];
    t = '{mk(1,2,3,3,1,1,0,0,1, 'b000000000), mk(1,1,3,3,2,1,0,1,1, 'b011000000),
          mk(1,2,9,1,10,1,0,0,1, 'b000000000), mk(0,0,0,0,0,0,0,0,1, 'b000000000)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(0, t[i]);
      @(negedge clk); ex = q.pop_front(); got = obs(ex.d); vecs++;
      if (got !== ex.v) begin errs++; $display("FAIL branch[%0d]: got %b want %b", i, got, ex.v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    row_t t[7];
    t = '{mk(1,0,0,1,4,1,1,0,1, 'b000000000), mk(0,0,0,0,0,0,0,0,1, 'b000000000),
          mk(0,0,0,0,0,0,0,1,0, 'b000100000), mk(0,0,0,0,0,0,0,0,0, 'b000100000),
          mk(0,0,0,0,0,0,0,0,0, 'b000100001), mk(1,4,4,3,5,1,0,0,1, 'b000000001),
          mk(0,0,0,0,0,0,0,0,1, 'b000010101)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(1, t[i]);
      @(negedge clk); ex = q.pop_front(); got = obs(ex.d); vecs++;
      if (got !== ex.v) begin errs++; $display("FAIL mem_wait[%0d]: got %b want %b", i, got, ex.v); end
      if (i == 5) begin
        vecs++;
        if (sc1 !== 32'd3) begin errs++; $display("FAIL mem_wait stall_cnt: got %0d want 3", sc1); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    row_t t[4];
    t = '{mk(1,0,0,1,4,1,1,0,1, 'b000000000), mk(0,0,0,0,0,0,0,0,1, 'b000000000),
          mk(0,0,0,0,0,0,0,0,0, 'b000100000), mk(0,0,0,0,0,0,0,0,0, 'b000100000)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, t[i]);
      @(negedge clk); ex = q.pop_front(); got = obs(ex.d); vecs++;
      if (got !== ex.v) begin errs++; $display("FAIL rst_wait[%0d]: got %b want %b", i, got, ex.v); end
      @(posedge clk); #1;
    end
    q.push_back('{1, 9'b000100001});
    ex = q.pop_front(); got = obs(ex.d); vecs++;
    if (got !== ex.v) begin errs++; $display("FAIL rst_wait pre: got %b want %b", got, ex.v); end
    #1 rst = 0;
    #1;
    q.push_back('{1, 9'b0});
    ex = q.pop_front(); got = obs(ex.d); vecs++;
    if (got !== ex.v || sc1 !== 32'd0) begin
      errs++; $display("FAIL rst_wait async: got %b cnt %0d want %b cnt 0", got, sc1, ex.v);
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    q.push_back('{1, 9'b0});
    @(negedge clk); ex = q.pop_front(); got = obs(ex.d); vecs++;
    if (got !== ex.v) begin errs++; $display("FAIL rst_wait post: got %b want %b", got, ex.v); end
  endtask

  initial begin
    test_reset();
    test_stall_no_fwd();
    test_forward();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control block for the 5-stage ARM core.
- Replaces the fixed hazard detector and the tied-off flush/freeze signals with one unit.
- Keeps its own scoreboard of the in-flight EXE/MEM/WB instructions.
- Generates stall, flush, global freeze and per-operand forwarding selects, plus memory wait-state freeze, a timeout flag and a stall counter.

Parameters:
- REG_AW, 4, register address width.
- N_SRC, 2, source operands checked per instruction.
- FWD_EN, 1, 1 = forwarding with load-use stall only; 0 = stall on any RAW against EXE/MEM.
- TIMEOUT, 255, max consecutive memory wait cycles before mem_timeout sets.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  valid instruction in ID.
- id_src  in  N_SRC*REG_AW  ID source register numbers; slice i = operand i.
- id_src_used  in  N_SRC  operand i is read.
- id_dest  in  REG_AW  ID destination.
- id_wb_en  in  1  ID instruction writes the register file.
- id_mem_r_en  in  1  ID instruction is a load.
- id_mem_w_en  in  1  ID instruction is a store.
- branch_taken  in  1  branch resolved taken in EXE.
- mem_ready  in  1  data memory completes the access this cycle.
- hazard_stall  out  1  freeze PC and IF/ID; insert bubble into ID/EX.
- flush_if  out  1  clear IF/ID.
- flush_id  out  1  clear ID/EX.
- freeze_all  out  1  hold every pipeline register and the PC.
- fwd_sel  out  N_SRC*2  per EXE operand: 0 = reg file, 1 = MEM-stage ALU result, 2 = WB value.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  cycles with hazard_stall or freeze_all high.

Behaviour:
- Reset (rst low, async): scoreboard slots EX/MEM/WB invalid; EX-aligned source registers cleared; all outputs 0; wait counter 0.
- Scoreboard slot fields: valid, dest, wb_en, mem_r_en, mem_acc (= r or w).
- Advance rule, on each clk edge with freeze_all = 0:
  - WB ← MEM; MEM ← EX.
  - EX ← ID fields, unless id_valid = 0, hazard_stall = 1 or flush_id = 1; then EX ← bubble (valid = 0).
  - EX-aligned srcs/used ← id_src/id_src_used under the same rule; a bubble clears used.
- freeze_all = 1: all slots and the EX-aligned sources hold.
- Hazard match (combinational): slot.valid & slot.wb_en & id_src_used[i] & id_src[i] == slot.dest, with id_valid = 1.
  - FWD_EN = 0: stall if any operand matches the EX or MEM slot.
  - FWD_EN = 1: stall only if it matches the EX slot and EX.mem_r_en = 1 (load-use; 1 bubble).
- WB slot never causes a stall: the register file is write-first.
- fwd_sel[i] (combinational, from EX-aligned sources), only when FWD_EN = 1 and used[i]:
  - MEM slot match with !mem_r_en → 1.
  - else WB slot match → 2.
  - else 0.
  - MEM match wins over WB match. FWD_EN = 0 → always 0.
- Branch: branch_taken → flush_if = flush_id = 1 in the same cycle.
- Memory wait FSM, states IDLE and WAIT:
  - IDLE → WAIT when MEM.valid & MEM.mem_acc & !mem_ready.
  - WAIT → IDLE on mem_ready.
  - freeze_all = MEM.valid & MEM.mem_acc & !mem_ready, combinational: a zero-wait access never freezes.
- Wait counter: increments each WAIT cycle, saturates, clears on return to IDLE.
  - Reaching TIMEOUT sets mem_timeout; it clears only on reset.
  - The pipeline stays frozen until mem_ready.
- Priority: freeze_all > flush > hazard_stall.
  - freeze_all = 1 forces flush_if, flush_id, hazard_stall to 0; a pending branch_taken re-asserts after the freeze because the EXE register holds.
  - flush and hazard in the same cycle: hazard_stall = 0, since the ID instruction is squashed.
- stall_cnt: +1 per cycle with hazard_stall | freeze_all; wraps at 2^CNT_W.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - slot struct typedef.
  - FWD_REG = 0, FWD_MEM = 1, FWD_WB = 2.
  - FSM state enum.
- Sub-module: pipe_scoreboard (3-slot shift register with hold and bubble insert), instantiated once.
- Compare/forward logic and FSM stay in the top.

Test Plan:
- FWD_EN = 0, ADD r1 then SUB r2,r1,r3 back-to-back → hazard_stall high 2 cycles, EX gets 2 bubbles, stall_cnt = 2.
- FWD_EN = 1, same pair → no stall; SUB in EXE sees fwd_sel[0] = 1. With one unrelated instruction between → fwd_sel[0] = 2.
- FWD_EN = 1, LDR r4 then ADD r5,r4,r4 → exactly 1 bubble, then fwd_sel = {2,2}.
- branch_taken together with a RAW hazard in ID → flush_if = flush_id = 1, hazard_stall = 0, EX slot invalid next cycle.
- Load in MEM with mem_ready low 3 cycles → freeze_all high 3 cycles, scoreboard unchanged. TIMEOUT = 2 → mem_timeout set at the 2nd wait cycle and stays set after mem_ready.
- Assert rst low mid-WAIT → outputs 0 immediately (async), FSM IDLE, mem_timeout cleared.
